cram_port_arb: RTL

Sequence-level arbiter sharing the single CRAM memory port between the CRAM store-sequence controller and the CRAM load-sequence controller. A requester acquires the port with its Acquirement token. It keeps the port, word by word, until its Termination token. The competing requester is held off with Nack. The block sits between both controllers and the CRAM array and muxes address, data and enables onto the array port.

---
 rtl/cram_port_arb_pkg.sv | 17 +
 rtl/cram_port_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cram_port_arb_pkg.sv
// Shared types for the CRAM port arbiter.
//   fsm_cram_arb  : arbiter state (idle, store owns port, load owns port)
//   cram_owner_e  : one-bit encoding of the last port owner, used for tie-breaking
package cram_port_arb_pkg;

  typedef enum logic [1:0] {
    aRB_IDLE = 2'd0,
    aRB_ST   = 2'd1,
    aRB_LD   = 2'd2
  } fsm_cram_arb;

  typedef enum logic {
    oWNER_ST = 1'b0,
    oWNER_LD = 1'b1
  } cram_owner_e;

endpackage

// File: rtl/cram_port_arb.sv
// Sequence-level arbiter for the single CRAM port, shared by the store-sequence and
// load-sequence controllers. A side acquires the port with Acq, keeps it for any
// number of per-word Req cycles, and releases it with Trm. The other side is stalled
// with Nack meanwhile.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   I_St_* / I_Ld_*         : Acq (sequence start), Req (word access), Trm (sequence end),
//                             Addr (word address), I_St_Data (store write data)
//   O_St_Grant / O_Ld_Grant : port owned by store / load (decoded from state register)
//   O_St_Nack / O_Ld_Nack   : stall to the requester
//   O_Mem_*                 : muxed CRAM port (WE, RE, Addr, Data)
//   O_Words                 : words issued in the current grant, saturating
module cram_port_arb
  import cram_port_arb_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR   = 10,
  parameter int unsigned WIDTH_DATA   = 32,
  parameter int unsigned WIDTH_LENGTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_St_Acq,
  input  logic                    I_St_Req,
  input  logic                    I_St_Trm,
  input  logic [WIDTH_ADDR-1:0]   I_St_Addr,
  input  logic [WIDTH_DATA-1:0]   I_St_Data,
  input  logic                    I_Ld_Acq,
  input  logic                    I_Ld_Req,
  input  logic                    I_Ld_Trm,
  input  logic [WIDTH_ADDR-1:0]   I_Ld_Addr,
  output logic                    O_St_Grant,
  output logic                    O_Ld_Grant,
  output logic                    O_St_Nack,
  output logic                    O_Ld_Nack,
  output logic                    O_Mem_WE,
  output logic                    O_Mem_RE,
  output logic [WIDTH_ADDR-1:0]   O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]   O_Mem_Data,
  output logic [WIDTH_LENGTH-1:0] O_Words
);

  fsm_cram_arb             state_q, state_d;
  cram_owner_e             last_q, last_d;
  logic                    st_pend_q, st_pend_d;
  logic                    ld_pend_q, ld_pend_d;
  logic [WIDTH_LENGTH-1:0] words_q, words_d;

  logic st_go, ld_go, owner_req, new_grant;

  // A side wants the port if it asks this cycle or was held off earlier.
  assign st_go = I_St_Acq | st_pend_q;
  assign ld_go = I_Ld_Acq | ld_pend_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      aRB_IDLE: begin
        // Trm is meaningless here; Acq alone decides.
        if (st_go && ld_go) state_d = (last_q == oWNER_LD) ? aRB_ST : aRB_LD;
        else if (st_go)     state_d = aRB_ST;
        else if (ld_go)     state_d = aRB_LD;
      end
      aRB_ST: if (I_St_Trm) state_d = ld_go ? aRB_LD : aRB_IDLE;
      aRB_LD: if (I_Ld_Trm) state_d = st_go ? aRB_ST : aRB_IDLE;
      default: state_d = aRB_IDLE;
    endcase
  end

  assign new_grant = (state_d != state_q) && (state_d != aRB_IDLE);
  assign owner_req = ((state_q == aRB_ST) && I_St_Req) || ((state_q == aRB_LD) && I_Ld_Req);

  always_comb begin
    // Pending is cleared on the edge the side gets the port; owner Acq never sets it.
    st_pend_d = (state_d == aRB_ST) ? 1'b0
                                    : (st_pend_q | (I_St_Acq & (state_q != aRB_ST)));
    ld_pend_d = (state_d == aRB_LD) ? 1'b0
                                    : (ld_pend_q | (I_Ld_Acq & (state_q != aRB_LD)));

    last_d = last_q;
    if (new_grant) last_d = (state_d == aRB_ST) ? oWNER_ST : oWNER_LD;

    words_d = words_q;
    if (new_grant)                      words_d = '0;
    else if (owner_req && words_q != '1) words_d = words_q + WIDTH_LENGTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= aRB_IDLE;
      last_q    <= oWNER_LD;
      st_pend_q <= 1'b0;
      ld_pend_q <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      st_pend_q <= st_pend_d;
      ld_pend_q <= ld_pend_d;
      words_q   <= words_d;
    end
  end

  assign O_St_Grant = (state_q == aRB_ST);
  assign O_Ld_Grant = (state_q == aRB_LD);
  assign O_St_Nack  = (I_St_Req | st_pend_q | I_St_Acq) & ~O_St_Grant;
  assign O_Ld_Nack  = (I_Ld_Req | ld_pend_q | I_Ld_Acq) & ~O_Ld_Grant;
  assign O_Words    = words_q;

  // Word accesses go straight through to the array in the Req cycle.
  always_comb begin
    O_Mem_WE   = 1'b0;
    O_Mem_RE   = 1'b0;
    O_Mem_Addr = '0;
    O_Mem_Data = '0;
    unique case (state_q)
      aRB_ST: begin
        O_Mem_WE   = I_St_Req;
        O_Mem_Addr = I_St_Addr;
        O_Mem_Data = I_St_Data;
      end
      aRB_LD: begin
        O_Mem_RE   = I_Ld_Req;
        O_Mem_Addr = I_Ld_Addr;
      end
      default: ;
    endcase
  end

endmodule
